// File: rtl/uart_transmitter_if.sv
// Parallel word handshake into the UART transmit FIFO.
interface uart_transmitter_if #(
    parameter int Data_length = 8
) ();
    logic [Data_length-1:0] parallel_datain;
    logic                   data_valid;
    logic                   data_ready;

    modport master (output parallel_datain, output data_valid, input data_ready);
    modport slave  (input parallel_datain, input data_valid, output data_ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit stage: small FIFO plus framer emitting a 4-bit length header,
// start bit, LSB-first data, optional parity and stop bit on baud ticks.
//
// state    | meaning
// S_IDLE   | line high, tx_done high, waiting for a queued word on a tick
// S_HEADER | four bit periods of frame length L, MSB first
// S_START  | one bit period of 0
// S_DATA   | Data_length bit periods, bit 0 first
// S_PARITY | one bit period of parity (only when parity_en)
// S_STOP   | one bit period of 1, then idle or straight into the next header
module uart_transmitter #(
    parameter int Data_length = 8,
    parameter int parity_en   = 1,
    parameter int clk_per_bit = 10,
    parameter int fifo_depth  = 4
) (
    input  logic              tx_clk,
    input  logic              rst,
    uart_transmitter_if.slave s_if,
    input  logic              parity_type,
    output logic              serialdata_out,
    output logic              tx_done,
    output logic              baudratetx
);
    localparam int BW    = (clk_per_bit > 2) ? $clog2(clk_per_bit) : 1;
    localparam int PW    = $clog2(fifo_depth);
    localparam int CNT_W = $clog2(Data_length + 1);
    localparam logic [3:0] HDR = 4'(Data_length + parity_en + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t                 r_state;
    logic [BW-1:0]          r_baud_cnt;
    logic [Data_length-1:0] r_mem [fifo_depth];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW:0]            r_count;
    logic [Data_length-1:0] r_shift;
    logic [3:0]             r_hdr;
    logic [1:0]             r_hdr_cnt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_par_type;
    logic                   r_parity;

    logic w_tick;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_tick     = (r_baud_cnt == BW'(clk_per_bit - 1));
    assign baudratetx = w_tick;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (PW+1)'(fifo_depth));
    assign s_if.data_ready = ~w_full;
    assign w_push     = s_if.data_valid & ~w_full;
    assign w_pop      = w_tick & ~w_empty & ((r_state == S_IDLE) | (r_state == S_STOP));

    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            r_baud_cnt <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_if.parallel_datain;
        end
    end

    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_shift        <= '0;
            r_hdr          <= '0;
            r_hdr_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_par_type     <= 1'b0;
            r_parity       <= 1'b0;
            serialdata_out <= 1'b1;
            tx_done        <= 1'b1;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift        <= r_mem[r_rd_ptr];
                        r_par_type     <= parity_type;
                        r_hdr          <= {HDR[2:0], 1'b0};
                        r_hdr_cnt      <= '0;
                        serialdata_out <= HDR[3];
                        tx_done        <= 1'b0;
                        r_state        <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (r_hdr_cnt == 2'd3) begin
                        serialdata_out <= 1'b0;
                        r_state        <= S_START;
                    end else begin
                        serialdata_out <= r_hdr[3];
                        r_hdr          <= {r_hdr[2:0], 1'b0};
                        r_hdr_cnt      <= r_hdr_cnt + 1'b1;
                    end
                end
                S_START: begin
                    serialdata_out <= r_shift[0];
                    r_parity       <= r_par_type ^ r_shift[0];
                    r_shift        <= r_shift >> 1;
                    r_bit_cnt      <= CNT_W'(1);
                    r_state        <= S_DATA;
                end
                S_DATA: begin
                    if (r_bit_cnt == CNT_W'(Data_length)) begin
                        if (parity_en != 0) begin
                            serialdata_out <= r_parity;
                            r_state        <= S_PARITY;
                        end else begin
                            serialdata_out <= 1'b1;
                            r_state        <= S_STOP;
                        end
                    end else begin
                        serialdata_out <= r_shift[0];
                        r_parity       <= r_parity ^ r_shift[0];
                        r_shift        <= r_shift >> 1;
                        r_bit_cnt      <= r_bit_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    serialdata_out <= 1'b1;
                    r_state        <= S_STOP;
                end
                S_STOP: begin
                    // tx_done pulses high for this one cycle even when the next header starts now
                    tx_done <= 1'b1;
                    if (w_pop) begin
                        r_shift        <= r_mem[r_rd_ptr];
                        r_par_type     <= parity_type;
                        r_hdr          <= {HDR[2:0], 1'b0};
                        r_hdr_cnt      <= '0;
                        serialdata_out <= HDR[3];
                        r_state        <= S_HEADER;
                    end else begin
                        serialdata_out <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    serialdata_out <= 1'b1;
                    tx_done        <= 1'b1;
                    r_state        <= S_IDLE;
                end
            endcase
        end else begin
            tx_done <= (r_state == S_IDLE);
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: default build and a 5-bit no-parity build.
module tb_uart_transmitter;
    logic clk;
    logic rst;
    logic ptype;
    logic ser_a, done_a, baud_a;
    logic ser_b, done_b, baud_b;
    int   n_checks;
    int   n_errors;

    uart_transmitter_if #(.Data_length(8)) bus_a ();
    uart_transmitter_if #(.Data_length(5)) bus_b ();

    uart_transmitter #(.Data_length(8), .parity_en(1), .clk_per_bit(10), .fifo_depth(4)) u_dut_a (
        .tx_clk(clk), .rst(rst), .s_if(bus_a.slave), .parity_type(ptype),
        .serialdata_out(ser_a), .tx_done(done_a), .baudratetx(baud_a)
    );

    uart_transmitter #(.Data_length(5), .parity_en(0), .clk_per_bit(10), .fifo_depth(4)) u_dut_b (
        .tx_clk(clk), .rst(rst), .s_if(bus_b.slave), .parity_type(ptype),
        .serialdata_out(ser_b), .tx_done(done_b), .baudratetx(baud_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int sel);
        return (sel != 0) ? done_b : done_a;
    endfunction

    function automatic logic ser_of(input int sel);
        return (sel != 0) ? ser_b : ser_a;
    endfunction

    function automatic logic baud_of(input int sel);
        return (sel != 0) ? baud_b : baud_a;
    endfunction

    task automatic wait_tick(input int sel);
        int c;
        c = 0;
        while (baud_of(sel) !== 1'b1 && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("tick_found", 32'(c < 30), 32'd1);
    endtask

    task automatic push(input int sel, input logic [7:0] d);
        if (sel != 0) begin
            bus_b.parallel_datain = d[4:0];
            bus_b.data_valid      = 1'b1;
        end else begin
            bus_a.parallel_datain = d;
            bus_a.data_valid      = 1'b1;
        end
        @(negedge clk);
        bus_a.data_valid = 1'b0;
        bus_b.data_valid = 1'b0;
    endtask

    // Samples each bit in the middle of its period, first bit ends up in the MSB position.
    task automatic capture(input int sel, input int nbits, output logic [15:0] bits,
                           output int low_len, output int wait_cyc);
        bits     = '0;
        wait_cyc = 0;
        while (done_of(sel) === 1'b1 && wait_cyc < 400) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("frame_start", 32'(wait_cyc < 400), 32'd1);
        low_len = 0;
        while (done_of(sel) === 1'b0 && low_len < 400) begin
            if (low_len % 10 == 5 && low_len / 10 < nbits) begin
                bits = {bits[14:0], ser_of(sel)};
            end
            @(negedge clk);
            low_len++;
        end
    endtask

    task automatic high_pulse(output int len);
        len = 0;
        while (done_a === 1'b1 && len < 400) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_a !== 1'b1 || ser_a !== 1'b1) lows++;
        end
    endtask

    initial begin
        logic [15:0] bits;
        logic [15:0] exp_b2b [4];
        int low_len, wait_cyc, pulse, lows, c;

        exp_b2b[0] = 16'h5A03;
        exp_b2b[1] = 16'h5903;
        exp_b2b[2] = 16'h5B01;
        exp_b2b[3] = 16'h5883;

        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        ptype = 1'b0;
        bus_a.data_valid = 1'b0;
        bus_a.parallel_datain = '0;
        bus_b.data_valid = 1'b0;
        bus_b.parallel_datain = '0;
        #3 rst = 1'b0;
        #1;
        chk("rst_ser", 32'(ser_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd1);
        chk("rst_ready", 32'(bus_a.data_ready), 32'd1);
        chk("rst_baud", 32'(baud_a), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // baud tick period
        wait_tick(0);
        @(negedge clk);
        c = 1;
        while (baud_a !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("baud_period", 32'(c), 32'd10);

        // 0xA5, even parity
        wait_tick(0);
        push(0, 8'hA5);
        capture(0, 15, bits, low_len, wait_cyc);
        chk("a5_even_bits", 32'(bits), 32'h5A95);
        chk("a5_even_low", 32'(low_len), 32'd150);
        chk("a5_latency", 32'(wait_cyc <= 10), 32'd1);

        // 0xA5, odd parity; parity_type flipped mid-frame must not matter
        repeat (20) @(negedge clk);
        ptype = 1'b1;
        wait_tick(0);
        push(0, 8'hA5);
        fork
            capture(0, 15, bits, low_len, wait_cyc);
            begin
                repeat (40) @(negedge clk);
                ptype = 1'b0;
            end
        join
        chk("a5_odd_bits", 32'(bits), 32'h5A97);
        chk("a5_odd_low", 32'(low_len), 32'd150);

        // fill FIFO: 4 accepted, 5th dropped, back-to-back frames
        repeat (20) @(negedge clk);
        wait_tick(0);
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        push(0, 8'h04);
        chk("full_ready_low", 32'(bus_a.data_ready), 32'd0);
        push(0, 8'h05);
        chk("full_ready_still_low", 32'(bus_a.data_ready), 32'd0);
        for (int f = 0; f < 4; f++) begin
            capture(0, 15, bits, low_len, wait_cyc);
            chk($sformatf("b2b_bits_%0d", f), 32'(bits), 32'(exp_b2b[f]));
            if (f == 0) chk("ready_after_pop", 32'(bus_a.data_ready), 32'd1);
            if (f < 3) begin
                high_pulse(pulse);
                chk($sformatf("b2b_pulse_%0d", f), 32'(pulse), 32'd1);
            end
        end
        count_low(300, lows);
        chk("no_fifth_frame", 32'(lows), 32'd0);

        // 5-bit, no parity build
        wait_tick(1);
        push(1, 8'h13);
        capture(1, 11, bits, low_len, wait_cyc);
        chk("d5_bits", 32'(bits), 32'h3B3);
        chk("d5_low", 32'(low_len), 32'd110);

        // reset during DATA with words still queued
        wait_tick(0);
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        c = 0;
        while (done_a === 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("rst_frame_started", 32'(c < 40), 32'd1);
        repeat (70) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ser", 32'(ser_a), 32'd1);
        chk("midrst_done", 32'(done_a), 32'd1);
        chk("midrst_ready", 32'(bus_a.data_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        count_low(400, lows);
        chk("midrst_queue_lost", 32'(lows), 32'd0);

        wait_tick(0);
        push(0, 8'h3C);
        capture(0, 15, bits, low_len, wait_cyc);
        chk("after_rst_bits", 32'(bits), 32'h58F1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
